// File: rtl/priority_encoder_8_to_3_if.sv
// Request/grant bundle for the 8-to-3 encoder.
// master drives the code side, slave drives requests and ready.
interface priority_encoder_8_to_3_if;
  logic       en;
  logic [7:0] in;
  logic       ready;
  logic [2:0] out;
  logic       valid;
  logic [7:0] pending;

  modport master (
    input  en,
    input  in,
    input  ready,
    output out,
    output valid,
    output pending
  );

  modport slave (
    output en,
    output in,
    output ready,
    input  out,
    input  valid,
    input  pending
  );
endinterface

// File: rtl/priority_encoder_8_to_3.sv
// Sticky-pending 8-to-3 encoder, one index per valid/ready handshake.
// Define ROUND_ROBIN_EN for rotating priority; default is highest-index wins.
module priority_encoder_8_to_3 (
  input logic clk,
  input logic rst,
  priority_encoder_8_to_3_if.master bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0] r_state;
  logic [7:0] r_pending;
  logic [2:0] r_out;

  logic       w_valid;
  logic       w_hs;
  logic       w_free;
  logic [7:0] w_clr;
  logic [7:0] w_set;
  logic [7:0] w_pnext;
  logic       w_any;
  logic [2:0] w_sel;

  assign w_valid = (r_state == S_HOLD);
  assign w_hs    = w_valid & bus.ready;
  assign w_free  = ~w_valid | w_hs;
  assign w_clr   = w_hs ? (8'b1 << r_out) : 8'h00;
  assign w_set   = bus.en ? bus.in : 8'h00;
  // set wins over clear on the same bit
  assign w_pnext = (r_pending & ~w_clr) | w_set;
  assign w_any   = |w_pnext;

`ifdef ROUND_ROBIN_EN
  logic [2:0] r_ptr;
  logic [2:0] w_idx;

  // later hits override earlier: scan ptr-8 .. ptr-1
  always_comb begin
    w_sel = 3'd0;
    w_idx = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      w_idx = r_ptr - 3'(k);
      if (w_pnext[w_idx]) w_sel = w_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 3'd0;
    end else if (w_free && w_any) begin
      r_ptr <= w_sel;
    end
  end
`else
  always_comb begin
    w_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_pnext[i]) w_sel = 3'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 8'h00;
      r_out     <= 3'd0;
    end else begin
      r_pending <= w_pnext;
      if (w_free) begin
        r_state <= w_any ? S_HOLD : S_IDLE;
        r_out   <= w_any ? w_sel : 3'd0;
      end
    end
  end

  assign bus.out     = r_out;
  assign bus.valid   = w_valid;
  assign bus.pending = r_pending;

endmodule
